// File: rtl/key_debounce_pkg.sv
// Shared constants for the key debouncer: key level encodings and default filter length.
package key_debounce_pkg;

  localparam logic KEY_PRESSED           = 1'b0;
  localparam logic KEY_RELEASED          = 1'b1;
  localparam int   DEFAULT_STABLE_CYCLES = 1000000;

endpackage

// File: rtl/key_debounce_if.sv
// Key-level bundle between the raw key pin side and the debouncer.
// Edge pulses exist only when KEY_DEBOUNCE_EDGE_EN is defined.
interface key_debounce_if;

  logic key_in;
  logic key_out;
`ifdef KEY_DEBOUNCE_EDGE_EN
  logic press_pulse;
  logic release_pulse;

  modport master (output key_in, input key_out, input press_pulse, input release_pulse);
  modport slave  (input key_in, output key_out, output press_pulse, output release_pulse);
`else
  modport master (output key_in, input key_out);
  modport slave  (input key_in, output key_out);
`endif

endinterface

// File: rtl/key_sync2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module key_sync2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic asyncLevel,
  output logic syncLevel
);

  logic sync1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= RESET_VAL;
      syncLevel <= RESET_VAL;
    end else begin
      sync1     <= asyncLevel;
      syncLevel <= sync1;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronise, then follow a new level only after STABLE_CYCLES
// consecutive samples. Define KEY_DEBOUNCE_EDGE_EN to add press/release pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic IDLE_LEVEL    = KEY_RELEASED
) (
  input logic           clk,
  input logic           reset,
  key_debounce_if.slave keyBus
);

  localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync2;
  logic             keyLevel;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             expire;

  key_sync2ff #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .asyncLevel (keyBus.key_in),
    .syncLevel  (sync2)
  );

  assign differs = (sync2 != keyLevel);
  assign expire  = differs && (cnt == CNT_LAST);

  // Any sample matching the current output restarts the count from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      keyLevel <= IDLE_LEVEL;
      cnt      <= '0;
    end else if (!differs) begin
      cnt      <= '0;
    end else if (expire) begin
      keyLevel <= sync2;
      cnt      <= '0;
    end else begin
      cnt      <= cnt + 1'b1;
    end
  end

  assign keyBus.key_out = keyLevel;

`ifdef KEY_DEBOUNCE_EDGE_EN
  logic pressPulse;
  logic releasePulse;

  // Pulses are registered on the same edge that updates keyLevel, so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
    end else begin
      pressPulse   <= expire && (sync2 != IDLE_LEVEL);
      releasePulse <= expire && (sync2 == IDLE_LEVEL);
    end
  end

  assign keyBus.press_pulse   = pressPulse;
  assign keyBus.release_pulse = releasePulse;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with STABLE_CYCLES=4 (6-edge latency from key_in change).
module tb_key_debounce;

  logic clk;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  key_debounce_if bus ();

  key_debounce #(
    .STABLE_CYCLES (4),
    .IDLE_LEVEL    (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .keyBus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic expOut;
    reset      = 1'b1;
    bus.key_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (bus.key_out !== 1'b1)
        $display("FAIL reset_hold cycle %0d: key_out=%b expected 1", i, bus.key_out);
      else passed++;
`ifdef KEY_DEBOUNCE_EDGE_EN
      total++;
      if (bus.press_pulse !== 1'b0 || bus.release_pulse !== 1'b0)
        $display("FAIL reset_pulses cycle %0d: press=%b release=%b expected 0 0",
                 i, bus.press_pulse, bus.release_pulse);
      else passed++;
`endif
    end
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      expOut = (i < 6) ? 1'b1 : 1'b0;
      total++;
      if (bus.key_out !== expOut)
        $display("FAIL reset_release_latency edge %0d: key_out=%b expected %b", i, bus.key_out, expOut);
      else passed++;
    end
  endtask

  task automatic test_clean_edge(input logic level);
    logic expOut;
    bus.key_in = level;
    for (int i = 1; i <= 7; i++) begin
      tick();
      expOut = (i < 6) ? ~level : level;
      total++;
      if (bus.key_out !== expOut)
        $display("FAIL clean_edge_to_%b edge %0d: key_out=%b expected %b", level, i, bus.key_out, expOut);
      else passed++;
`ifdef KEY_DEBOUNCE_EDGE_EN
      total++;
      if (bus.press_pulse !== ((i == 6) && (level == 1'b0)) ||
          bus.release_pulse !== ((i == 6) && (level == 1'b1)))
        $display("FAIL edge_pulses_to_%b edge %0d: press=%b release=%b expected %b %b",
                 level, i, bus.press_pulse, bus.release_pulse,
                 (i == 6) && (level == 1'b0), (i == 6) && (level == 1'b1));
      else passed++;
`endif
    end
  endtask

  task automatic test_clean_press_release();
    test_clean_edge(1'b1);
    test_clean_edge(1'b0);
    test_clean_edge(1'b1);
  endtask

  task automatic test_bounce();
    logic expOut;
    for (int i = 0; i < 10; i++) begin
      bus.key_in = i[0];
      tick();
      total++;
      if (bus.key_out !== 1'b1)
        $display("FAIL bounce_hold cycle %0d: key_out=%b expected 1", i, bus.key_out);
      else passed++;
    end
    bus.key_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      expOut = (i < 6) ? 1'b1 : 1'b0;
      total++;
      if (bus.key_out !== expOut)
        $display("FAIL bounce_settle edge %0d: key_out=%b expected %b", i, bus.key_out, expOut);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    bus.key_in = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    total++;
    if (bus.key_out !== 1'b1)
      $display("FAIL glitch_setup: key_out=%b expected 1", bus.key_out);
    else passed++;
    for (int i = 1; i <= 11; i++) begin
      bus.key_in = (i <= 3) ? 1'b0 : 1'b1;
      tick();
      total++;
      if (bus.key_out !== 1'b1)
        $display("FAIL glitch_reject cycle %0d: key_out=%b expected 1", i, bus.key_out);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_count();
    logic expOut;
    bus.key_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (bus.key_out !== 1'b1)
        $display("FAIL midcount_pre cycle %0d: key_out=%b expected 1", i, bus.key_out);
      else passed++;
    end
    reset = 1'b1;
    tick();
    total++;
    if (bus.key_out !== 1'b1)
      $display("FAIL midcount_in_reset: key_out=%b expected 1", bus.key_out);
    else passed++;
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      expOut = (i < 6) ? 1'b1 : 1'b0;
      total++;
      if (bus.key_out !== expOut)
        $display("FAIL midcount_after_reset edge %0d: key_out=%b expected %b", i, bus.key_out, expOut);
      else passed++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.key_in = 1'b1;
    test_reset();
    test_clean_press_release();
    test_bounce();
    test_glitch();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
